// File: rtl/mnk_game_pkg.sv
// Shared types, result codes and direction helpers
// for the N x N, K-in-a-row game controller.
package mnk_game_pkg;

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_CHECK   = 2'd1,
    S_RELEASE = 2'd2,
    S_RESULT  = 2'd3
  } state_e;

  localparam logic [1:0] RES_PLAY = 2'b00;
  localparam logic [1:0] RES_X    = 2'b01;
  localparam logic [1:0] RES_O    = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam logic [1:0] DIR_H = 2'd0;
  localparam logic [1:0] DIR_V = 2'd1;
  localparam logic [1:0] DIR_D = 2'd2;
  localparam logic [1:0] DIR_A = 2'd3;

  function automatic int dir_dr(logic [1:0] d);
    return (d == DIR_H) ? 0 : 1;
  endfunction

  function automatic int dir_dc(logic [1:0] d);
    int v;
    unique case (d)
      DIR_H, DIR_D: v = 1;
      DIR_V:        v = 0;
      default:      v = -1;
    endcase
    return v;
  endfunction

  function automatic int cell_idx(int row, int col, int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/mnk_game_ctrl_line_run_count.sv
// Contiguous run of one player's cells through a position
// along one direction, both senses, clipped at board edges.
module line_run_count
  import mnk_game_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic [N*N-1:0]           brd_i,
  input  logic [$clog2(N*N)-1:0]   pos_i,
  input  logic [1:0]               dir_i,
  output logic [$clog2(K+1)-1:0]   cnt_o,
  output logic [N*N-1:0]           mask_o
);
  localparam int PW = $clog2(N * N);
  localparam int CW = $clog2(K + 1);

  int r0, c0, dr, dc, r, c, len;
  logic live;
  logic [PW-1:0] idx;

  always_comb begin
    r0 = int'(pos_i) / N;
    c0 = int'(pos_i) % N;
    dr = dir_dr(dir_i);
    dc = dir_dc(dir_i);
    r = 0;
    c = 0;
    idx = '0;
    len = 0;
    mask_o = '0;
    live = brd_i[pos_i];
    if (live) begin
      mask_o[pos_i] = 1'b1;
      len = 1;
    end
    for (int s = 1; s < N; s++) begin
      r = r0 + s * dr;
      c = c0 + s * dc;
      idx = PW'(cell_idx(r, c, N));
      if (live && r >= 0 && r < N &&
          c >= 0 && c < N && brd_i[idx]) begin
        mask_o[idx] = 1'b1;
        len++;
      end else begin
        live = 1'b0;
      end
    end
    live = brd_i[pos_i];
    for (int s = 1; s < N; s++) begin
      r = r0 - s * dr;
      c = c0 - s * dc;
      idx = PW'(cell_idx(r, c, N));
      if (live && r >= 0 && r < N &&
          c >= 0 && c < N && brd_i[idx]) begin
        mask_o[idx] = 1'b1;
        len++;
      end else begin
        live = 1'b0;
      end
    end
    cnt_o = (len >= K) ? CW'(K) : CW'(len);
  end

endmodule

// File: rtl/mnk_game_ctrl.sv
// N x N K-in-a-row controller: board, turns, one-direction-
// per-cycle win/draw check, win mask and saturating scores.
module mnk_game_ctrl
  import mnk_game_pkg::*;
#(
  parameter int N       = 3,
  parameter int K       = 3,
  parameter int SCORE_W = 4
) (
  input  logic               clk_100MHz,
  input  logic               rst_n,
  input  logic [N*N-1:0]     cell_sel,
  input  logic               new_game,
  input  logic               clear_score,
  input  logic               ack,
  input  logic               first_o,
  output logic [N*N-1:0]     board_x,
  output logic [N*N-1:0]     board_o,
  output logic               turn_x,
  output logic               busy,
  output logic [1:0]         result,
  output logic [N*N-1:0]     win_line,
  output logic [SCORE_W-1:0] score_x,
  output logic [SCORE_W-1:0] score_o,
  output logic [1:0]         state
);
  localparam int NC = N * N;
  localparam int PW = $clog2(NC);
  localparam int CW = $clog2(K + 1);
  localparam logic [SCORE_W-1:0] SMAX = '1;

  state_e st_q, st_d;
  logic [NC-1:0] bx_q, bx_d, bo_q, bo_d;
  logic [NC-1:0] win_q, win_d;
  logic turn_q, turn_d;
  logic [1:0] res_q, res_d, dir_q, dir_d;
  logic [PW-1:0] pos_q, pos_d, sel_idx;
  logic [SCORE_W-1:0] sx_q, sx_d, so_q, so_d;
  logic inc_x, inc_o, sel_any;
  logic [CW-1:0] run_cnt;
  logic [NC-1:0] run_mask, mover;

  always_comb begin
    sel_idx = '0;
    for (int i = NC - 1; i >= 0; i--)
      if (cell_sel[i]) sel_idx = PW'(i);
  end

  assign sel_any = |cell_sel;
  assign mover = turn_q ? bx_q : bo_q;

  line_run_count #(.N(N), .K(K)) u_run (
    .brd_i  (mover),
    .pos_i  (pos_q),
    .dir_i  (dir_q),
    .cnt_o  (run_cnt),
    .mask_o (run_mask)
  );

  always_comb begin
    st_d = st_q;
    bx_d = bx_q;
    bo_d = bo_q;
    win_d = win_q;
    turn_d = turn_q;
    res_d = res_q;
    dir_d = dir_q;
    pos_d = pos_q;
    inc_x = 1'b0;
    inc_o = 1'b0;
    unique case (st_q)
      S_WAIT: begin
        if (sel_any) begin
          if (!(bx_q[sel_idx] | bo_q[sel_idx])) begin
            if (turn_q) bx_d[sel_idx] = 1'b1;
            else        bo_d[sel_idx] = 1'b1;
            pos_d = sel_idx;
            dir_d = DIR_H;
            st_d = S_CHECK;
          end else begin
            st_d = S_RELEASE;
          end
        end
      end
      S_CHECK: begin
        if (run_cnt == CW'(K)) begin
          win_d = run_mask;
          res_d = turn_q ? RES_X : RES_O;
          inc_x = turn_q;
          inc_o = !turn_q;
          st_d = S_RESULT;
        end else if (dir_q == DIR_A && &(bx_q | bo_q)) begin
          res_d = RES_DRAW;
          st_d = S_RESULT;
        end else if (dir_q == DIR_A) begin
          turn_d = ~turn_q;
          st_d = S_RELEASE;
        end else begin
          dir_d = dir_q + 2'd1;
        end
      end
      S_RELEASE: begin
        if (!sel_any) st_d = S_WAIT;
      end
      S_RESULT: begin
        if (ack) begin
          bx_d = '0;
          bo_d = '0;
          win_d = '0;
          res_d = RES_PLAY;
          turn_d = ~first_o;
          st_d = S_RELEASE;
        end
      end
      default: st_d = S_WAIT;
    endcase
    // Overrides everything above except the score increment.
    if (new_game) begin
      bx_d = '0;
      bo_d = '0;
      win_d = '0;
      res_d = RES_PLAY;
      turn_d = ~first_o;
      dir_d = DIR_H;
      st_d = S_RELEASE;
    end
    sx_d = sx_q;
    so_d = so_q;
    if (inc_x && sx_q != SMAX) sx_d = sx_q + SCORE_W'(1);
    if (inc_o && so_q != SMAX) so_d = so_q + SCORE_W'(1);
    if (clear_score) begin
      sx_d = '0;
      so_d = '0;
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= S_WAIT;
      bx_q <= '0;
      bo_q <= '0;
      win_q <= '0;
      turn_q <= 1'b1;
      res_q <= RES_PLAY;
      dir_q <= DIR_H;
      pos_q <= '0;
      sx_q <= '0;
      so_q <= '0;
    end else begin
      st_q <= st_d;
      bx_q <= bx_d;
      bo_q <= bo_d;
      win_q <= win_d;
      turn_q <= turn_d;
      res_q <= res_d;
      dir_q <= dir_d;
      pos_q <= pos_d;
      sx_q <= sx_d;
      so_q <= so_d;
    end
  end

  assign board_x = bx_q;
  assign board_o = bo_q;
  assign turn_x = turn_q;
  assign busy = (st_q == S_CHECK);
  assign result = res_q;
  assign win_line = win_q;
  assign score_x = sx_q;
  assign score_o = so_q;
  assign state = st_q;

endmodule

// File: tb/tb_mnk_game_ctrl.sv
// Bench: 3x3/K=3/SCORE_W=2 and 5x5/K=4 controllers driven
// from a move table, with a queue of expected outcomes.
module tb_mnk_game_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [8:0] cs3, bx3, bo3, wl3;
  logic ng3, cls3, ack3, fo3, tx3, busy3;
  logic [1:0] res3, sx3, so3, st3;

  logic [24:0] cs5, bx5, bo5, wl5;
  logic ng5, cls5, ack5, fo5, tx5, busy5;
  logic [1:0] res5, st5;
  logic [3:0] sx5, so5;

  mnk_game_ctrl #(.N(3), .K(3), .SCORE_W(2)) dut3 (
    .clk_100MHz(clk), .rst_n(rst_n), .cell_sel(cs3),
    .new_game(ng3), .clear_score(cls3), .ack(ack3),
    .first_o(fo3), .board_x(bx3), .board_o(bo3),
    .turn_x(tx3), .busy(busy3), .result(res3),
    .win_line(wl3), .score_x(sx3), .score_o(so3),
    .state(st3)
  );

  mnk_game_ctrl #(.N(5), .K(4), .SCORE_W(4)) dut5 (
    .clk_100MHz(clk), .rst_n(rst_n), .cell_sel(cs5),
    .new_game(ng5), .clear_score(cls5), .ack(ack5),
    .first_o(fo5), .board_x(bx5), .board_o(bo5),
    .turn_x(tx5), .busy(busy5), .result(res5),
    .win_line(wl5), .score_x(sx5), .score_o(so5),
    .state(st5)
  );

  typedef struct {
    logic [8:0] sel;
    logic [1:0] res;
    int         cyc;
    logic [8:0] wl;
  } vec_t;

  typedef struct {
    logic [8:0] bx, bo, wl;
    logic       tx;
    logic [1:0] res, st, sx, so;
    int         cyc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] mbx, mbo;
  logic mtx;
  logic [1:0] msx, mso;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [8:0] s, input logic [1:0] r,
                     input int c, input logic [8:0] w);
    vec_t v;
    v.sel = s; v.res = r; v.cyc = c; v.wl = w;
    tbl.push_back(v);
  endtask

  task automatic wait_check(output int cyc, input logic b5);
    @(posedge clk);
    @(negedge clk);
    cyc = 0;
    while ((b5 ? busy5 : busy3) && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic play3(input vec_t v);
    exp_t e;
    int p, cyc;
    p = 0;
    for (int i = 8; i >= 0; i--) if (v.sel[i]) p = i;
    if (!(mbx[p] | mbo[p])) begin
      if (mtx) mbx[p] = 1'b1;
      else     mbo[p] = 1'b1;
      if (v.res == 2'b00) mtx = ~mtx;
    end
    if (v.res == 2'b01 && msx != 2'd3) msx++;
    if (v.res == 2'b10 && mso != 2'd3) mso++;
    e.bx = mbx; e.bo = mbo; e.wl = v.wl; e.tx = mtx;
    e.res = v.res; e.sx = msx; e.so = mso; e.cyc = v.cyc;
    e.st = (v.res != 2'b00) ? 2'd3 : 2'd2;
    sb.push_back(e);
    cs3 = v.sel;
    wait_check(cyc, 1'b0);
    e = sb.pop_front();
    chk("check_cycles", cyc, e.cyc);
    chk("result", res3, e.res);
    chk("win_line", wl3, e.wl);
    chk("board_x", bx3, e.bx);
    chk("board_o", bo3, e.bo);
    chk("turn_x", tx3, e.tx);
    chk("state", st3, e.st);
    chk("score_x", sx3, e.sx);
    chk("score_o", so3, e.so);
    cs3 = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_ack();
    ack3 = 1'b1;
    @(negedge clk);
    ack3 = 1'b0;
    mbx = '0; mbo = '0; mtx = ~fo3;
    chk("ack_state", st3, 2'd2);
    chk("ack_board", {bx3, bo3}, 18'd0);
    chk("ack_result", {res3, wl3}, 11'd0);
    chk("ack_turn", tx3, mtx);
    chk("ack_scores", {sx3, so3}, {msx, mso});
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish, want finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int seq5[7];
    seq5 = '{4, 0, 8, 1, 12, 2, 16};
    rst_n = 1'b0;
    cs3 = '0; ng3 = 0; cls3 = 0; ack3 = 0; fo3 = 0;
    cs5 = '0; ng5 = 0; cls5 = 0; ack5 = 0; fo5 = 0;
    mbx = '0; mbo = '0; mtx = 1'b1; msx = '0; mso = '0;

    // horizontal X win
    add(9'h001, 0, 4, 0); add(9'h008, 0, 4, 0);
    add(9'h002, 0, 4, 0); add(9'h010, 0, 4, 0);
    add(9'h004, 1, 1, 9'h007); add(0, 0, 0, 0);
    // draw
    add(9'h001, 0, 4, 0); add(9'h002, 0, 4, 0);
    add(9'h004, 0, 4, 0); add(9'h010, 0, 4, 0);
    add(9'h008, 0, 4, 0); add(9'h020, 0, 4, 0);
    add(9'h080, 0, 4, 0); add(9'h040, 0, 4, 0);
    add(9'h100, 3, 4, 0); add(0, 0, 0, 0);
    // occupied click, multi-bit select, anti-diagonal X win
    add(9'h010, 0, 4, 0); add(9'h010, 0, 0, 0);
    add(9'h00A, 0, 4, 0); add(9'h004, 0, 4, 0);
    add(9'h001, 0, 4, 0); add(9'h040, 1, 4, 9'h054);
    add(0, 0, 0, 0);
    // vertical X win
    add(9'h001, 0, 4, 0); add(9'h002, 0, 4, 0);
    add(9'h008, 0, 4, 0); add(9'h004, 0, 4, 0);
    add(9'h040, 1, 2, 9'h049); add(0, 0, 0, 0);
    // fourth X win, score saturated
    add(9'h001, 0, 4, 0); add(9'h008, 0, 4, 0);
    add(9'h002, 0, 4, 0); add(9'h010, 0, 4, 0);
    add(9'h004, 1, 1, 9'h007); add(0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    chk("rst_board", {bx3, bo3}, 18'd0);
    chk("rst_turn", tx3, 1'b1);
    chk("rst_busy", busy3, 1'b0);
    chk("rst_result", res3, 2'd0);
    chk("rst_win", wl3, 9'd0);
    chk("rst_scores", {sx3, so3}, 4'd0);
    chk("rst_state", st3, 2'd0);
    chk("rst_turn5", tx5, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      cs5 = '0;
      cs5[seq5[i]] = 1'b1;
      wait_check(cyc, 1'b1);
      if (i < 6) begin
        chk("n5_move_cycles", cyc, 4);
        cs5 = '0;
        @(negedge clk);
        @(negedge clk);
      end
    end
    chk("n5_win_cycles", cyc, 4);
    chk("n5_result", res5, 2'b01);
    chk("n5_win_line", wl5, 25'h0011110);
    chk("n5_board_x", bx5, 25'h0011110);
    chk("n5_board_o", bo5, 25'h0000007);
    chk("n5_score_x", sx5, 4'd1);
    chk("n5_state", st5, 2'd3);
    cs5 = '0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].sel == 9'd0) do_ack();
      else play3(tbl[i]);
    end

    cs3 = 9'h010;
    repeat (12) @(negedge clk);
    chk("hold_board_x", bx3, 9'h010);
    chk("hold_board_o", bo3, 9'h000);
    chk("hold_turn", tx3, 1'b0);
    chk("hold_state", st3, 2'd2);
    cs3 = '0;
    @(negedge clk);
    @(negedge clk);

    fo3 = 1'b1;
    ng3 = 1'b1;
    @(negedge clk);
    ng3 = 1'b0;
    mbx = '0; mbo = '0; mtx = 1'b0;
    chk("ng_board", {bx3, bo3}, 18'd0);
    chk("ng_turn", tx3, 1'b0);
    chk("ng_state", st3, 2'd2);
    chk("ng_score_x", sx3, msx);
    @(negedge clk);

    begin
      vec_t v;
      v.res = 0; v.cyc = 4; v.wl = 0;
      v.sel = 9'h001; play3(v);
      v.sel = 9'h008; play3(v);
      v.sel = 9'h002; play3(v);
      v.sel = 9'h010; play3(v);
    end
    cs3 = 9'h004;
    @(posedge clk);
    @(negedge clk);
    cls3 = 1'b1;
    @(negedge clk);
    cls3 = 1'b0;
    mbo = mbo | 9'h004; msx = '0; mso = '0;
    chk("clr_result", res3, 2'b10);
    chk("clr_win_line", wl3, 9'h007);
    chk("clr_scores", {sx3, so3}, 4'd0);
    chk("clr_state", st3, 2'd3);
    cs3 = '0;
    @(negedge clk);
    do_ack();

    cs3 = 9'h010;
    @(posedge clk);
    #2;
    chk("pre_rst_busy", busy3, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_board", {bx3, bo3}, 18'd0);
    chk("arst_turn", tx3, 1'b1);
    chk("arst_busy", busy3, 1'b0);
    chk("arst_state", st3, 2'd0);
    chk("arst_res_win", {res3, wl3}, 11'd0);
    cs3 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mbx = '0; mbo = '0; mtx = 1'b1;
    begin
      vec_t v;
      v.sel = 9'h010; v.res = 0; v.cyc = 4; v.wl = 0;
      play3(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
